// File: rtl/data_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared slave side
// (address decoder, RAM, GPIO).
//
// Handshake: a master raises reqN together with its address, data, mask and
// write enable, and holds all of them stable until it sees gntN high. Each
// cycle with gntN high is exactly one completed beat. A write commits at the
// rising edge that ends the granted cycle. Read data is returned in the same
// cycle on rdata. A beat granted in the cycle that reqN drops still executes,
// so a master must gate its own strobes on reqN.
interface data_bus_arbiter_if;
   logic        req0;
   logic        lock0;
   logic        we0;
   logic [31:0] addr0;
   logic [31:0] wdata0;
   logic [3:0]  mask0;
   logic        gnt0;

   logic        req1;
   logic        lock1;
   logic        we1;
   logic [31:0] addr1;
   logic [31:0] wdata1;
   logic [3:0]  mask1;
   logic        gnt1;

   logic [31:0] rdata;
   logic [31:0] sAddr;
   logic [31:0] sWdata;
   logic [3:0]  sMask;
   logic        sWe;
   logic [31:0] sRdata;

   logic        lockErr;
   logic        lockErrClr;

   // Arbiter view: takes master requests and slave read data, drives grants
   // and the shared slave-side bus.
   modport slave (
      input  req0, lock0, we0, addr0, wdata0, mask0,
      input  req1, lock1, we1, addr1, wdata1, mask1,
      input  sRdata, lockErrClr,
      output gnt0, gnt1, rdata, sAddr, sWdata, sMask, sWe, lockErr
   );

   // Surrounding-system view: masters and slaves facing the arbiter.
   modport master (
      output req0, lock0, we0, addr0, wdata0, mask0,
      output req1, lock1, we1, addr1, wdata1, mask1,
      output sRdata, lockErrClr,
      input  gnt0, gnt1, rdata, sAddr, sWdata, sMask, sWe, lockErr
   );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master per-beat round-robin arbiter with a bounded bus lock.
// Master 0 is the CPU data port, master 1 the loader/DMA/debug master.
// The granted master's signals are steered combinationally onto the slave
// side, so a granted beat completes in the cycle it is granted.
// o_dbg_state exposes the FSM: 0 = IDLE, 1 = GNT0, 2 = GNT1.
module data_bus_arbiter #(
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              reset,
   data_bus_arbiter_if.slave bus,
   output logic [1:0]        o_dbg_state
);

   localparam int             HW        = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(LOCK_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [HW-1:0]  r_hold_cnt;
   logic           r_last_owner;
   logic           r_lock_err;
   logic           w_lock_break;

   // Next-state decision: round-robin on contention, lock honoured until the
   // holder has used LOCK_MAX consecutive cycles while the other master waits.
   always_comb begin
      w_next_state = r_state;
      w_lock_break = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.req0 && bus.req1)
               w_next_state = r_last_owner ? ST_GNT0 : ST_GNT1;
            else if (bus.req0)
               w_next_state = ST_GNT0;
            else if (bus.req1)
               w_next_state = ST_GNT1;
         end
         ST_GNT0: begin
            if (!bus.req0) begin
               w_next_state = bus.req1 ? ST_GNT1 : ST_IDLE;
            end else if (!bus.lock0) begin
               if (bus.req1) w_next_state = ST_GNT1;
            end else if (bus.req1 && (r_hold_cnt == HOLD_LAST)) begin
               w_next_state = ST_GNT1;
               w_lock_break = 1'b1;
            end
         end
         ST_GNT1: begin
            if (!bus.req1) begin
               w_next_state = bus.req0 ? ST_GNT0 : ST_IDLE;
            end else if (!bus.lock1) begin
               if (bus.req0) w_next_state = ST_GNT0;
            end else if (bus.req0 && (r_hold_cnt == HOLD_LAST)) begin
               w_next_state = ST_GNT0;
               w_lock_break = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register; reset drops any grant immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // Consecutive-hold counter: restarts on every ownership change and in
   // IDLE, saturates at LOCK_MAX-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_hold_cnt <= '0;
      else if ((w_next_state != r_state) || (w_next_state == ST_IDLE))
         r_hold_cnt <= '0;
      else if (r_hold_cnt != HOLD_LAST)
         r_hold_cnt <= r_hold_cnt + 1'b1;
   end

   // Remember the last master that entered a grant; starts at 1 so that
   // master 0 wins the first contention after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_last_owner <= 1'b1;
      else if ((w_next_state == ST_GNT0) && (r_state != ST_GNT0))
         r_last_owner <= 1'b0;
      else if ((w_next_state == ST_GNT1) && (r_state != ST_GNT1))
         r_last_owner <= 1'b1;
   end

   // Sticky lock-break flag; a break in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              r_lock_err <= 1'b0;
      else if (w_lock_break)   r_lock_err <= 1'b1;
      else if (bus.lockErrClr) r_lock_err <= 1'b0;
   end

   // Slave-side steering straight from the state register, quiet in IDLE.
   always_comb begin
      bus.sAddr  = '0;
      bus.sWdata = '0;
      bus.sMask  = '0;
      bus.sWe    = 1'b0;
      case (r_state)
         ST_GNT0: begin
            bus.sAddr  = bus.addr0;
            bus.sWdata = bus.wdata0;
            bus.sMask  = bus.mask0;
            bus.sWe    = bus.we0;
         end
         ST_GNT1: begin
            bus.sAddr  = bus.addr1;
            bus.sWdata = bus.wdata1;
            bus.sMask  = bus.mask1;
            bus.sWe    = bus.we1;
         end
         default: ;
      endcase
   end

   assign bus.gnt0    = (r_state == ST_GNT0);
   assign bus.gnt1    = (r_state == ST_GNT1);
   assign bus.rdata   = bus.sRdata;
   assign bus.lockErr = r_lock_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: a vector table, hand-written
// multi-cycle sequences (lock hold, lock timeout, reset mid-beat) and a
// randomized run against an ownership/tenure reference model.
module tb_data_bus_arbiter;

   localparam int LOCK_MAX = 16;

   logic        clk;
   logic        reset;
   logic [1:0]  dbg_state;
   logic [31:0] mem [0:255];

   int n_checks;
   int n_pass;

   // reference model: current owner (-1 idle), last owner, cycles owned so far
   int m_owner;
   int m_last;
   int m_tenure;
   bit m_err;

   typedef struct {
      logic        req0;
      logic        lock0;
      logic        we0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic        req1;
      logic        lock1;
      logic        we1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        g0;
      logic        g1;
      logic        err;
      logic        chk_rd;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl [14];

   data_bus_arbiter_if bus ();

   data_bus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock and slave memory (combinational read, masked synchronous write)
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.sRdata = mem[bus.sAddr[9:2]];

   always @(posedge clk) begin
      if (reset && bus.sWe) begin
         for (int b = 0; b < 4; b++)
            if (bus.sMask[b]) mem[bus.sAddr[9:2]][8*b +: 8] <= bus.sWdata[8*b +: 8];
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [71:0] pack_out();
      return {bus.gnt0, bus.gnt1, bus.sWe, bus.sMask, bus.lockErr, bus.sAddr, bus.sWdata};
   endfunction

   task automatic clear_inputs();
      bus.req0 = 1'b0; bus.lock0 = 1'b0; bus.we0 = 1'b0;
      bus.addr0 = '0; bus.wdata0 = '0; bus.mask0 = 4'hF;
      bus.req1 = 1'b0; bus.lock1 = 1'b0; bus.we1 = 1'b0;
      bus.addr1 = '0; bus.wdata1 = '0; bus.mask1 = 4'hF;
      bus.lockErrClr = 1'b0;
   endtask

   task automatic model_reset();
      m_owner = -1; m_last = 1; m_tenure = 0; m_err = 1'b0;
   endtask

   // one clock edge of the arbitration rules, from the inputs now applied
   task automatic model_step();
      bit rq [2];
      bit lk [2];
      int nxt;
      bit brk;
      rq[0] = bus.req0; rq[1] = bus.req1;
      lk[0] = bus.lock0; lk[1] = bus.lock1;
      brk = 1'b0;
      if (m_owner < 0) begin
         if (rq[0] && rq[1]) nxt = 1 - m_last;
         else if (rq[0])     nxt = 0;
         else if (rq[1])     nxt = 1;
         else                nxt = -1;
      end else begin
         int x = m_owner;
         int y = 1 - m_owner;
         if (!rq[x])                               nxt = rq[y] ? y : -1;
         else if (!lk[x])                          nxt = rq[y] ? y : x;
         else if (rq[y] && m_tenure >= LOCK_MAX) begin nxt = y; brk = 1'b1; end
         else                                      nxt = x;
      end
      if (nxt != m_owner) begin
         m_tenure = (nxt < 0) ? 0 : 1;
         if (nxt >= 0) m_last = nxt;
      end else if (nxt >= 0) begin
         m_tenure++;
      end
      if (brk)                 m_err = 1'b1;
      else if (bus.lockErrClr) m_err = 1'b0;
      m_owner = nxt;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      clear_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   // watchdog: the run is fixed-length, this only guards against a stall
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      localparam logic N = 1'b0;
      localparam logic Y = 1'b1;
      localparam logic [31:0] Z  = 32'h0;
      localparam logic [31:0] A  = 32'h100;
      localparam logic [31:0] D  = 32'hDEADBEEF;
      localparam logic [31:0] A0 = 32'h200;
      localparam logic [31:0] D0 = 32'h11111111;
      localparam logic [31:0] A1 = 32'h300;
      localparam logic [31:0] D1 = 32'h22222222;
      vec_t v;
      logic        e_we;
      logic [3:0]  e_mask;
      logic [31:0] e_addr;
      logic [31:0] e_data;

      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b0;
      clear_inputs();
      model_reset();

      //            req0 lk0 we0 a0  d0   req1 lk1 we1 a1  d1   g0 g1 err chk rd
      tbl[0]  = '{N, N, N, Z,  Z,  N, N, N, Z,  Z,  N, N, N, N, Z};
      tbl[1]  = '{N, N, N, Z,  Z,  Y, N, Y, A,  D,  N, N, N, N, Z};
      tbl[2]  = '{Y, N, N, A,  Z,  N, N, Y, A,  D,  N, Y, N, N, Z};
      tbl[3]  = '{Y, N, N, A,  Z,  N, N, N, Z,  Z,  Y, N, N, Y, D};
      tbl[4]  = '{N, N, N, A,  Z,  N, N, N, Z,  Z,  Y, N, N, Y, D};
      tbl[5]  = '{N, N, N, Z,  Z,  N, N, N, Z,  Z,  N, N, N, N, Z};
      tbl[6]  = '{Y, N, Y, A0, D0, Y, N, Y, A1, D1, N, N, N, N, Z};
      tbl[7]  = '{Y, N, Y, A0, D0, Y, N, Y, A1, D1, N, Y, N, N, Z};
      tbl[8]  = '{Y, N, Y, A0, D0, Y, N, Y, A1, D1, Y, N, N, N, Z};
      tbl[9]  = '{Y, N, Y, A0, D0, Y, Y, Y, A1, D1, N, Y, N, N, Z};
      tbl[10] = '{Y, N, Y, A0, D0, N, N, Y, A1, D1, N, Y, N, N, Z};
      tbl[11] = '{N, N, N, Z,  Z,  N, N, N, Z,  Z,  Y, N, N, N, Z};
      tbl[12] = '{N, N, N, Z,  Z,  Y, N, N, A0, Z,  N, N, N, N, Z};
      tbl[13] = '{N, N, N, Z,  Z,  Y, N, N, A0, Z,  N, Y, N, Y, D0};

      // reset then idle
      do_reset();
      #1;
      check("reset_idle", {bus.gnt0, bus.gnt1, bus.sWe, bus.lockErr, bus.sAddr}, '0);
      check("reset_dbg_state", dbg_state, 2'd0);
      @(negedge clk);

      // vector table: single-master write/read-back, round-robin, plain lock
      for (int i = 0; i < 14; i++) begin
         v = tbl[i];
         bus.req0 = v.req0; bus.lock0 = v.lock0; bus.we0 = v.we0;
         bus.addr0 = v.a0; bus.wdata0 = v.d0;
         bus.req1 = v.req1; bus.lock1 = v.lock1; bus.we1 = v.we1;
         bus.addr1 = v.a1; bus.wdata1 = v.d1;
         #1;
         e_we   = v.g0 ? v.we0 : (v.g1 ? v.we1 : 1'b0);
         e_mask = (v.g0 || v.g1) ? 4'hF : 4'h0;
         e_addr = v.g0 ? v.a0 : (v.g1 ? v.a1 : 32'h0);
         e_data = v.g0 ? v.d0 : (v.g1 ? v.d1 : 32'h0);
         check($sformatf("vec%0d", i), pack_out(), {v.g0, v.g1, e_we, e_mask, v.err, e_addr, e_data});
         if (v.chk_rd) check($sformatf("vec%0d_rdata", i), bus.rdata, v.rd);
         @(negedge clk);
      end

      // lock honoured with no competing request
      do_reset();
      bus.req0 = 1'b1; bus.lock0 = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         #1;
         check($sformatf("lock_hold_c%0d", i), {bus.gnt0, bus.gnt1, bus.lockErr}, 3'b100);
         @(negedge clk);
      end

      // lock timeout: competitor arrives on the first held cycle
      do_reset();
      bus.req0 = 1'b1; bus.lock0 = 1'b1;
      @(negedge clk);
      bus.req1 = 1'b1;
      for (int i = 0; i < LOCK_MAX; i++) begin
         #1;
         check($sformatf("lock_to_c%0d", i), {bus.gnt0, bus.gnt1, bus.lockErr}, 3'b100);
         @(negedge clk);
      end
      #1;
      check("lock_to_break", {bus.gnt0, bus.gnt1, bus.lockErr}, 3'b011);
      clear_inputs();
      repeat (3) @(negedge clk);
      #1;
      check("lock_err_sticky", bus.lockErr, 1'b1);
      @(negedge clk);
      bus.lockErrClr = 1'b1;
      @(negedge clk);
      bus.lockErrClr = 1'b0;
      #1;
      check("lock_err_clr", bus.lockErr, 1'b0);

      // break and clear in the same cycle: the break wins
      do_reset();
      bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.lockErrClr = 1'b1;
      @(negedge clk);
      bus.req1 = 1'b1;
      repeat (LOCK_MAX) @(negedge clk);
      #1;
      check("set_wins", {bus.gnt0, bus.gnt1, bus.lockErr}, 3'b011);
      @(negedge clk);
      #1;
      check("clr_after_set", bus.lockErr, 1'b0);

      // reset in the middle of a master 1 write beat
      do_reset();
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h40; bus.wdata1 = 32'hA5A5A5A5;
      @(negedge clk);
      #1;
      check("midbeat_pre", {bus.gnt1, bus.sWe}, 2'b11);
      #1;
      reset = 1'b0;
      #1;
      check("midbeat_async", {bus.gnt0, bus.gnt1, bus.sWe, bus.sAddr}, '0);
      @(negedge clk);
      reset = 1'b1;
      clear_inputs();
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      @(negedge clk);
      #1;
      check("midbeat_first_contention", {bus.gnt0, bus.gnt1}, 2'b10);
      @(negedge clk);

      // randomized bursts against the reference model
      do_reset();
      for (int cyc = 0; cyc < 600; ) begin
         int  blen;
         logic r0, l0, r1, l1;
         blen = $urandom_range(1, 22);
         r0 = ($urandom_range(0, 3) != 0);
         l0 = ($urandom_range(0, 1) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         l1 = ($urandom_range(0, 1) != 0);
         for (int k = 0; k < blen; k++) begin
            logic [31:0] x_addr;
            logic [31:0] x_data;
            logic [3:0]  x_mask;
            logic        x_we;
            bus.req0 = r0; bus.lock0 = l0; bus.req1 = r1; bus.lock1 = l1;
            bus.we0 = 1'($urandom_range(0, 1));
            bus.addr0 = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            bus.wdata0 = $urandom();
            bus.mask0 = 4'($urandom_range(0, 15));
            bus.we1 = 1'($urandom_range(0, 1));
            bus.addr1 = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            bus.wdata1 = $urandom();
            bus.mask1 = 4'($urandom_range(0, 15));
            bus.lockErrClr = ($urandom_range(0, 11) == 0);
            #1;
            if (m_owner == 0) begin
               x_addr = bus.addr0; x_data = bus.wdata0; x_mask = bus.mask0; x_we = bus.we0;
            end else if (m_owner == 1) begin
               x_addr = bus.addr1; x_data = bus.wdata1; x_mask = bus.mask1; x_we = bus.we1;
            end else begin
               x_addr = '0; x_data = '0; x_mask = '0; x_we = 1'b0;
            end
            check($sformatf("rand_c%0d", cyc), pack_out(),
                  {(m_owner == 0), (m_owner == 1), x_we, x_mask, m_err, x_addr, x_data});
            check($sformatf("rand_rdata_c%0d", cyc), bus.rdata, mem[x_addr[9:2]]);
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
Two-master arbiter for the single data-memory/peripheral bus that currently hangs directly off the CPU. Master 0 is the CPU data port; master 1 is a secondary bus master (program loader/DMA/debug). The arbiter grants the bus per beat, round-robin, with an optional bounded lock, and drives the shared slave-side address, data, mask and write-enable into the address decoder, RAM and GPIO. Combinational-read/synchronous-write slaves are implied, so a granted beat completes in the cycle it is granted.

Parameters:
LOCK_MAX, 16, maximum consecutive granted cycles a locking master may hold the bus while the other master is requesting; must be >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  master 0 (CPU) bus request
lock0  input  1  master 0 requests to keep the bus after the current beat
we0  input  1  master 0 write enable
addr0  input  32  master 0 address
wdata0  input  32  master 0 write data
mask0  input  4  master 0 byte write mask
gnt0  output  1  master 0 owns the bus this cycle (registered)
req1, lock1, we1, addr1, wdata1, mask1  input  1/1/1/32/32/4  master 1 equivalents
gnt1  output  1  master 1 owns the bus this cycle (registered)
rdata  output  32  read data, broadcast to both masters; valid only for the granted master
sAddr  output  32  slave-side address
sWdata  output  32  slave-side write data
sMask  output  4  slave-side byte mask
sWe  output  1  slave-side write enable
sRdata  input  32  slave-side read data
lockErr  output  1  sticky: a lock was forcibly broken
lockErrClr  input  1  clears lockErr

Behaviour:
- Reset, asynchronous while reset=0: state=IDLE, gnt0=gnt1=0, lastOwner=1 (master 0 wins the first contention), holdCnt=0, lockErr=0.
- States: IDLE, GNT0, GNT1. gnt0=(state==GNT0) and gnt1=(state==GNT1). Exactly one or neither grant is ever high.
- IDLE: if req0 and req1 are both high, grant the master that is not lastOwner. If only one master requests, grant that master. If neither requests, stay in IDLE.
- GNTx, with y the other master:
  - reqx=0: go to GNTy if reqy, else go to IDLE.
  - reqx=1, lockx=0: go to GNTy if reqy; otherwise stay in GNTx.
  - reqx=1, lockx=1: stay in GNTx, unless reqy=1 and holdCnt==LOCK_MAX-1. In that case go to GNTy and set lockErr.
- lastOwner updates to x on every entry into GNTx.
- holdCnt:
  - Cleared on any state change and in IDLE.
  - Otherwise increments each cycle the state stays in GNTx, saturating at LOCK_MAX-1.
  - Width is clog2(LOCK_MAX).
- Grant latency: a request seen with the bus idle produces a grant on the next edge (1 cycle). A master must hold req and its bus signals stable until it sees its grant.
- Datapath is purely combinational from state:
  - GNTx: sAddr/sWdata/sMask = master x signals; sWe = wex.
  - IDLE: sAddr=0, sWdata=0, sMask=0, sWe=0.
  - rdata = sRdata at all times.
- One beat equals one granted cycle. A write commits at the clock edge that ends the granted cycle.
- If req drops in the same cycle as the grant arrives, the beat still executes, including any write. Masters must gate their own strobes on req.
- If lockErrClr and a lock-break happen in the same cycle, set wins.
- Mid-operation reset forces IDLE immediately. sWe deasserts asynchronously with the reset.

Test Plan:
- Reset then idle: reset low for 3 cycles, release -> gnt0=gnt1=0, sWe=0, sAddr=0, lockErr=0.
- Single master write: req1=1, we1=1, addr1=0x100, wdata1=0xDEADBEEF, mask1=4'hF from an idle bus -> gnt1=1 on the next cycle, sWe=1, sAddr=0x100 for that cycle; a following read at 0x100 by master 0 returns rdata=0xDEADBEEF.
- Contention round-robin: req0=req1=1 held continuously from reset, no locks -> grants alternate gnt0, gnt1, gnt0, gnt1 on consecutive cycles with no IDLE gap.
- Lock honoured: master 0 holds lock0=1 with req0=1 while req1=0 for 40 cycles -> gnt0 stays high for all 40 cycles and lockErr=0.
- Lock timeout, LOCK_MAX=16: master 0 locked, req1 asserted at cycle 0 of the hold -> gnt0 for 16 cycles, then gnt1; lockErr=1 and stays 1 until a lockErrClr pulse.
- Reset mid-beat: assert reset while gnt1=1 and we1=1 -> gnt1 and sWe go low immediately; after release, master 0 wins the first contention.
